// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Generic pipeline register with a two-entry skid buffer. It carries an
//   opaque payload from an upstream stage to a downstream stage using
//   valid/ready handshakes. in_ready comes straight from a flop, so the ready
//   chain never forms a combinational path across stages. flush drops
//   everything the stage holds, and hold stops the stage presenting data
//   downstream while it still accepts new data.
//
//   Optional feature macro: PIPE_STAGE_PERF_EN
//     defined   : stall and bubble counters are built (saturating, cleared by reset)
//     undefined : both counter ports are tied to zero and no counter flops exist
//
// Parameters:
//   PAYLOAD_W  width of the payload bundle
//   RESET_VAL  value loaded into both payload entries on reset
//   CNT_W      width of the performance counters
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-high reset (beats flush and handshakes)
//   flush            empty the stage and drop this cycle's input
//   hold             hazard stall: suppress out_valid, keep accepting input
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload (main entry)
//   perf_stall_cnt   cycles where a valid main entry was not taken
//   perf_bubble_cnt  cycles where the main entry was empty

module pipe_stage_skid #(
  parameter int                   PAYLOAD_W = 160,
  parameter logic [PAYLOAD_W-1:0] RESET_VAL = {PAYLOAD_W{1'b0}},
  parameter int                   CNT_W     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 hold,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [CNT_W-1:0]     perf_stall_cnt,
  output logic [CNT_W-1:0]     perf_bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 in_ready_q;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic                 acc;
  logic                 take;
  logic                 main_load;
  logic                 main_from_skid;
  logic                 skid_load;

  assign in_ready = in_ready_q;
  assign out_data = main_q;

  // State register. in_ready is registered from the next state, so it always
  // equals (state != TWO) without out_ready reaching it combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != TWO);
    end
  end

  // Next-state and handshake decode. Flush forces EMPTY; because acc and take
  // are both masked by flush, no entry is written on a flush cycle.
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    out_valid      = (state != EMPTY) & ~hold & ~flush;
    acc            = in_valid & in_ready_q & ~flush;
    take           = out_valid & out_ready;

    case (state)
      EMPTY: begin
        if (acc) begin
          state_next = ONE;
          main_load  = 1'b1;
        end
      end
      ONE: begin
        if (acc && take) begin
          main_load = 1'b1;
        end else if (acc) begin
          state_next = TWO;
          skid_load  = 1'b1;
        end else if (take) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (take) begin
          state_next     = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    if (flush) begin
      state_next = EMPTY;
    end
  end

  // Payload entries. The main entry is what downstream sees; the skid entry
  // catches the one payload that arrives while main is stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      if (main_load) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  assign perf_stall_cnt  = stall_q;
  assign perf_bubble_cnt = bubble_q;

  // Saturating counters; flush does not clear them, and a flush cycle does
  // not count as a stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if ((state != EMPTY) && !take && !flush && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
      if ((state == EMPTY) && (bubble_q != {CNT_W{1'b1}})) begin
        bubble_q <= bubble_q + 1'b1;
      end
    end
  end
`else
  assign perf_stall_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
//   Bench for pipe_stage_skid: a table of directed vectors with hand-computed
//   expected outputs, a counter saturation sequence, then random traffic
//   checked against a queue-based reference model.

module tb_pipe_stage_skid;

  localparam int           W    = 16;
  localparam int           CW   = 4;
  localparam logic [W-1:0] RV   = 16'hDEAD;
  localparam int           CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          hold;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] perf_stall_cnt;
  logic [CW-1:0] perf_bubble_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: payloads held by the stage, oldest first.
  logic [W-1:0] mq[$];
  bit           mainKnown;
  int           stallM;
  int           bubbleM;

  typedef struct {
    bit           r;
    bit           f;
    bit           h;
    bit           iv;
    logic [W-1:0] d;
    bit           ordy;
    bit           er;
    bit           ev;
    bit           cd;
    logic [W-1:0] ed;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  pipe_stage_skid #(
    .PAYLOAD_W (W),
    .RESET_VAL (RV),
    .CNT_W     (CW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .hold            (hold),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  // Single comparison: counts, and reports a FAIL line on mismatch.
  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void addVec(input bit r, input bit f, input bit h, input bit iv,
                                 input logic [W-1:0] d, input bit ordy, input bit er,
                                 input bit ev, input bit cd, input logic [W-1:0] ed);
    vec_t v;
    v.r = r; v.f = f; v.h = h; v.iv = iv; v.d = d; v.ordy = ordy;
    v.er = er; v.ev = ev; v.cd = cd; v.ed = ed;
    vecs.push_back(v);
  endfunction

  // Drive one cycle's inputs just after the rising edge, then wait for the
  // falling edge where outputs are sampled.
  task automatic applyStimulus(input bit r, input bit f, input bit h, input bit iv,
                               input logic [W-1:0] d, input bit ordy);
    reset     = r;
    flush     = f;
    hold      = h;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clock);
  endtask

  // Compare against hand-computed values from a table row.
  task automatic checkOutput(input string tag, input bit er, input bit ev,
                             input bit cd, input logic [W-1:0] ed);
    cmp({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    cmp({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    if (cd) cmp({tag, ".out_data"}, 32'(out_data), 32'(ed));
  endtask

  // Compare against the reference model.
  task automatic checkModel(input string tag);
    cmp({tag, ".m_in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
    cmp({tag, ".m_out_valid"}, 32'(out_valid), 32'((mq.size() > 0) && !hold && !flush));
    if (mq.size() > 0) cmp({tag, ".m_out_data"}, 32'(out_data), 32'(mq[0]));
    else if (mainKnown) cmp({tag, ".m_out_data_rst"}, 32'(out_data), 32'(RV));
`ifdef PIPE_STAGE_PERF_EN
    cmp({tag, ".m_stall_cnt"}, 32'(perf_stall_cnt), 32'(stallM));
    cmp({tag, ".m_bubble_cnt"}, 32'(perf_bubble_cnt), 32'(bubbleM));
`else
    cmp({tag, ".m_stall_cnt"}, 32'(perf_stall_cnt), 32'd0);
    cmp({tag, ".m_bubble_cnt"}, 32'(perf_bubble_cnt), 32'd0);
`endif
  endtask

  // Model update from the inputs of the current cycle, then cross the edge.
  task automatic advance();
    bit expValid;
    bit acc;
    bit take;
    if (reset) begin
      mq.delete();
      mainKnown = 1'b1;
      stallM    = 0;
      bubbleM   = 0;
    end else begin
      expValid = (mq.size() > 0) && !hold && !flush;
      acc      = in_valid && (mq.size() < 2) && !flush;
      take     = expValid && out_ready;
      if ((mq.size() > 0) && !take && !flush && (stallM < CMAX)) stallM++;
      if ((mq.size() == 0) && (bubbleM < CMAX)) bubbleM++;
      if (flush) begin
        mq.delete();
      end else begin
        if (take) void'(mq.pop_front());
        if (acc) begin
          mq.push_back(in_data);
          mainKnown = 1'b0;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mainKnown = 1'b1; stallM = 0; bubbleM = 0;

    // Initial reset; outputs are unknown before the first edge.
    applyStimulus(1, 0, 0, 0, '0, 0);
    advance();

    // Reset state, then streaming 1..10 at full rate.
    addVec(0,0,0,0,16'h0000,1, 1,0,1,RV);
    addVec(0,0,0,1,16'd1,1,     1,0,1,RV);
    for (int i = 2; i <= 10; i++) addVec(0,0,0,1,16'(i),1, 1,1,1,16'(i-1));
    addVec(0,0,0,0,16'h0000,1, 1,1,1,16'd10);
    addVec(0,0,0,0,16'h0000,1, 1,0,0,16'h0000);
    // Backpressure into the skid entry, then drain A, B, C.
    addVec(0,0,0,1,16'h000A,0, 1,0,0,16'h0000);
    addVec(0,0,0,1,16'h000B,0, 1,1,1,16'h000A);
    addVec(0,0,0,1,16'h000C,0, 0,1,1,16'h000A);
    addVec(0,0,0,1,16'h000C,1, 0,1,1,16'h000A);
    addVec(0,0,0,1,16'h000C,1, 1,1,1,16'h000B);
    addVec(0,0,0,0,16'h0000,1, 1,1,1,16'h000C);
    addVec(0,0,0,0,16'h0000,1, 1,0,0,16'h0000);
    // Hold for three cycles: 0x6 goes to skid, then 0x5 and 0x6 drain.
    addVec(0,0,0,1,16'h0005,1, 1,0,0,16'h0000);
    addVec(0,0,1,1,16'h0006,1, 1,0,1,16'h0005);
    addVec(0,0,1,0,16'h0000,1, 0,0,1,16'h0005);
    addVec(0,0,1,0,16'h0000,1, 0,0,1,16'h0005);
    addVec(0,0,0,0,16'h0000,1, 0,1,1,16'h0005);
    addVec(0,0,0,0,16'h0000,1, 1,1,1,16'h0006);
    addVec(0,0,0,0,16'h0000,1, 1,0,0,16'h0000);
    // Flush while full with 0x33 offered; 0x44 must be the next output.
    addVec(0,0,0,1,16'h0011,0, 1,0,0,16'h0000);
    addVec(0,0,0,1,16'h0022,0, 1,1,1,16'h0011);
    addVec(0,1,0,1,16'h0033,1, 0,0,0,16'h0000);
    addVec(0,0,0,0,16'h0000,1, 1,0,0,16'h0000);
    addVec(0,0,0,1,16'h0044,1, 1,0,0,16'h0000);
    addVec(0,0,0,0,16'h0000,1, 1,1,1,16'h0044);
    // Reset while full.
    addVec(0,0,0,1,16'h0071,0, 1,0,0,16'h0000);
    addVec(0,0,0,1,16'h0072,0, 1,1,1,16'h0071);
    addVec(1,0,0,1,16'h0073,0, 0,1,1,16'h0071);
    addVec(0,0,0,0,16'h0000,0, 1,0,1,RV);
    addVec(0,0,0,0,16'h0000,0, 1,0,1,RV);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].f, vecs[i].h, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      checkOutput($sformatf("vec%0d", i), vecs[i].er, vecs[i].ev, vecs[i].cd, vecs[i].ed);
      checkModel($sformatf("vec%0d", i));
      advance();
    end

    // Stall counter saturation: one entry parked for 20 cycles.
    applyStimulus(1, 0, 0, 0, '0, 0);
    advance();
    applyStimulus(0, 0, 0, 1, 16'h0055, 0);
    checkModel("sat_load");
    advance();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, '0, 0);
      checkModel($sformatf("sat%0d", i));
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, '0, 0);
`ifdef PIPE_STAGE_PERF_EN
      cmp($sformatf("sat_stall_hold%0d", i), 32'(perf_stall_cnt), 32'(CMAX));
      cmp($sformatf("sat_bubble%0d", i), 32'(perf_bubble_cnt), 32'd1);
`else
      cmp($sformatf("sat_stall_hold%0d", i), 32'(perf_stall_cnt), 32'd0);
      cmp($sformatf("sat_bubble%0d", i), 32'(perf_bubble_cnt), 32'd0);
`endif
      cmp($sformatf("sat_data%0d", i), 32'(out_data), 32'h0055);
      advance();
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 63) == 0,
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) != 0,
                    W'($urandom),
                    $urandom_range(0, 2) != 0);
      checkModel($sformatf("rnd%0d", i));
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
